// File: rtl/aac_row_sequencer.sv
// Row sequencer for the 12+12 split adder-accumulator: streams products in, captures row sums out.
// Optional AAC_ROWTAG_EN adds res_row, the row index of the held result.
module aac_row_sequencer #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ROW_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ROW_W-1:0]  cfg_rows,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              acc_aac,
    output logic [DATA_W-1:0] acc_a,
    input  logic [DATA_W-1:0] acc_out,
    output logic              res_valid,
    input  logic              res_ready,
`ifdef AAC_ROWTAG_EN
    output logic [ROW_W-1:0]  res_row,
`endif
    output logic [DATA_W-1:0] res_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_CAPT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_col_cnt;
    logic [LEN_W-1:0]   r_last_col;
    logic [LEN_W-1:0]   w_col_nxt;
    logic [ROW_W-1:0]   r_row_cnt;
    logic [ROW_W-1:0]   r_last_row;
    logic               r_done;
    logic               r_res_valid;
    logic [DATA_W-1:0]  r_res_data;
    logic               w_capture;
    logic               w_last_row;
    logic               w_take_beat;
`ifdef AAC_ROWTAG_EN
    logic [ROW_W-1:0]   r_res_row;
`endif

    assign w_last_row = (r_row_cnt == r_last_row);

    // Next state and accumulator drive; a CAPT cycle that frees a row also accepts the next row's first beat
    always_comb begin
        w_next      = r_state;
        w_col_nxt   = r_col_cnt;
        w_capture   = 1'b0;
        w_take_beat = 1'b0;
        in_ready    = 1'b0;
        acc_aac     = 1'b0;
        acc_a       = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready    = 1'b1;
                acc_aac     = 1'b1;
                w_take_beat = in_valid;
            end
            S_CAPT: begin
                acc_aac = 1'b1;
                if (!r_res_valid || res_ready) begin
                    w_capture = 1'b1;
                    if (w_last_row) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next      = S_ACCUM;
                        in_ready    = 1'b1;
                        w_take_beat = in_valid;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (w_take_beat) begin
            acc_a   = in_data;
            acc_aac = (r_col_cnt != '0);
            if (r_col_cnt == r_last_col) begin
                w_col_nxt = '0;
                w_next    = S_CAPT;
            end else begin
                w_col_nxt = r_col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Job configuration and counters; cfg value 0 wraps to all-ones, encoding the full 2^W count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_last_col <= '0;
            r_last_row <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_last_col <= LEN_W'(cfg_len - 1'b1);
                r_last_row <= ROW_W'(cfg_rows - 1'b1);
                r_col_cnt  <= '0;
                r_row_cnt  <= '0;
            end
        end else begin
            r_col_cnt <= w_col_nxt;
            if (w_capture) begin
                r_row_cnt <= r_row_cnt + 1'b1;
            end
        end
    end

    // Result register: a new capture wins over a same-cycle read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_done      <= 1'b0;
`ifdef AAC_ROWTAG_EN
            r_res_row   <= '0;
`endif
        end else begin
            r_done <= w_capture && w_last_row;
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_data  <= acc_out;
`ifdef AAC_ROWTAG_EN
                r_res_row   <= r_row_cnt;
`endif
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
`ifdef AAC_ROWTAG_EN
    assign res_row   = r_res_row;
`endif

endmodule

// File: tb/tb_aac_row_sequencer.sv
// Directed bench for aac_row_sequencer with a behavioural 24-bit accumulator and a row-sum scoreboard.
module tb_aac_row_sequencer;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned ROW_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic [ROW_W-1:0]  cfg_rows;
    logic              busy;
    logic              done;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              acc_aac;
    logic [DATA_W-1:0] acc_a;
    logic [DATA_W-1:0] acc_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
`ifdef AAC_ROWTAG_EN
    logic [ROW_W-1:0]  res_row;
`endif

    int n_vec  = 0;
    int n_err  = 0;
    int stalls = 0;
    logic [DATA_W-1:0] sb_q[$];

    aac_row_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ROW_W(ROW_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_len(cfg_len), .cfg_rows(cfg_rows),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .acc_aac(acc_aac), .acc_a(acc_a), .acc_out(acc_out),
        .res_valid(res_valid), .res_ready(res_ready),
`ifdef AAC_ROWTAG_EN
        .res_row(res_row),
`endif
        .res_data(res_data)
    );

    always #5 clk = ~clk;

    // Accumulator: aac=0 loads A, aac=1 adds A; out lags inputs by one cycle
    logic [DATA_W-1:0] acc_reg;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     acc_reg <= '0;
        else if (!acc_aac) acc_reg <= acc_a;
        else              acc_reg <= acc_reg + acc_a;
    end
    assign acc_out = acc_reg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any handshake completing at this edge, then settle 1 time unit past it
    task automatic step();
        logic [DATA_W-1:0] e;
        @(negedge clk);
        if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("sb_row_sum", 32'(res_data), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input int bubbles);
        bit ok = 0;
        in_valid = 1'b0;
        repeat (bubbles) step();
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 40; k++) begin
            if (in_ready) begin
                ok = 1;
                step();
                break;
            end
            stalls++;
            step();
        end
        if (!ok) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic start_job(input logic [LEN_W-1:0] len, input logic [ROW_W-1:0] rows);
        cfg_len  = len;
        cfg_rows = rows;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (sb_q.size() == 0 && !busy && !res_valid) break;
            step();
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        cfg_rows  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_acc_aac", 32'(acc_aac), 32'd0);
        chk("rst_acc_a", 32'(acc_a), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // len=4 rows=1: 1+2+3+4
        start_job(8'd4, 8'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        sb_q.push_back(24'd10);
        beat(24'd1, 0);
        chk("t1_first_aac", 32'(acc_aac), 32'd1);
        beat(24'd2, 0);
        beat(24'd3, 0);
        beat(24'd4, 0);
        in_valid = 1'b0;
        chk("t1_capt_res_valid", 32'(res_valid), 32'd0);
        chk("t1_capt_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("t1_res_valid", 32'(res_valid), 32'd1);
        chk("t1_res_data", 32'(res_data), 32'd10);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_off", 32'(busy), 32'd0);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);
        drain();

        // len=3 rows=2 back-to-back rows
        start_job(8'd3, 8'd2);
        sb_q.push_back(24'd11);
        sb_q.push_back(24'd600);
        stalls = 0;
        beat(24'd5, 0);
        beat(24'hFFFFFF, 0);
        beat(24'd7, 0);
        beat(24'd100, 0);
        beat(24'd200, 0);
        beat(24'd300, 0);
        in_valid = 1'b0;
        chk("t2_no_gap", 32'(stalls), 32'd0);
        drain();

        // Carry across the 12-bit split
        start_job(8'd2, 8'd1);
        sb_q.push_back(24'h001000);
        beat(24'h000FFF, 0);
        beat(24'h000001, 0);
        in_valid = 1'b0;
        drain();

        // Bubbles and wrap mod 2^24
        start_job(8'd4, 8'd1);
        sb_q.push_back(24'h800000);
        beat(24'h7FFFFF, 2);
        beat(24'd1, 2);
        beat(24'd0, 1);
        beat(24'd0, 3);
        in_valid = 1'b0;
        drain();

        // Back-pressure on the result register
        res_ready = 1'b0;
        start_job(8'd1, 8'd2);
        sb_q.push_back(24'd9);
        sb_q.push_back(24'd13);
        beat(24'd9, 0);
        beat(24'd13, 0);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t5_stall_in_ready", 32'(in_ready), 32'd0);
            chk("t5_stall_res_data", 32'(res_data), 32'd9);
            chk("t5_stall_busy", 32'(busy), 32'd1);
            step();
        end
        res_ready = 1'b1;
        step();
        chk("t5_row2_loaded", 32'(res_data), 32'd13);
        chk("t5_row2_valid", 32'(res_valid), 32'd1);
        drain();

        // Reset mid-row discards the partial job
        start_job(8'd4, 8'd1);
        beat(24'd50, 0);
        beat(24'd60, 0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_res_valid", 32'(res_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        start_job(8'd2, 8'd1);
        sb_q.push_back(24'd7);
        beat(24'd3, 0);
        beat(24'd4, 0);
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
